// File: rtl/full_adder.sv
// Single-bit full adder with a zero-latency combinational result and a
// registered shadow copy plus a saturating carry-out event counter.
module full_adder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             cout,
    output logic             sum_q,
    output logic             cout_q,
    output logic [CNT_W-1:0] cout_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

    // The counter sticks at all-ones so a long run of carries never wraps back to a small value.
    always_comb begin
        cnt_d = cnt_q;
        if (cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
            cnt_q  <= cnt_d;
        end
    end

    assign cout_cnt = cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: truth table, directed clocked sequence,
// registered path, async reset, random vectors and counter saturation.
module tb_full_adder;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic expSum;
        logic expCout;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        rstSat_n;
    logic        a;
    logic        b;
    logic        cin;
    logic        sum;
    logic        cout;
    logic        sum_q;
    logic        cout_q;
    logic [15:0] cout_cnt;
    logic        satSum;
    logic        satCout;
    logic        satSumQ;
    logic        satCoutQ;
    logic [1:0]  satCnt;

    int compared   = 0;
    int mismatched = 0;

    full_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .sum_q    (sum_q),
        .cout_q   (cout_q),
        .cout_cnt (cout_cnt)
    );

    full_adder #(.CNT_W(2)) dutSat (
        .clk      (clk),
        .rst_n    (rstSat_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (satSum),
        .cout     (satCout),
        .sum_q    (satSumQ),
        .cout_q   (satCoutQ),
        .cout_cnt (satCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic va, input logic vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
    endtask

    vec_t tt[8];
    vec_t seq[7];
    int   satExp[5];
    int   expCnt;
    logic curCarry;
    logic [1:0] total;

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        seq[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seq[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        seq[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        seq[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        seq[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        satExp = '{1, 2, 3, 3, 3};

        rst_n    = 1'b0;
        rstSat_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_sum_q", 32'(sum_q), 32'(0));
        checkOutput("rst_cout_q", 32'(cout_q), 32'(0));
        checkOutput("rst_cout_cnt", 32'(cout_cnt), 32'(0));

        // Truth table is applied while reset is still held: the combinational path must not care.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tt[i].a, tt[i].b, tt[i].cin);
            #3;
            checkOutput($sformatf("tt%0d_sum", i), 32'(sum), 32'(tt[i].expSum));
            checkOutput($sformatf("tt%0d_cout", i), 32'(cout), 32'(tt[i].expCout));
        end
        checkOutput("rst_hold_cout_cnt", 32'(cout_cnt), 32'(0));

        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        rstSat_n = 1'b1;
        expCnt   = 0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            applyStimulus(seq[i].a, seq[i].b, seq[i].cin);
            #1;
            checkOutput($sformatf("seq%0d_neg_sum", i), 32'(sum), 32'(seq[i].expSum));
            checkOutput($sformatf("seq%0d_neg_cout", i), 32'(cout), 32'(seq[i].expCout));
            @(posedge clk);
            #1;
            if (seq[i].expCout) expCnt++;
            checkOutput($sformatf("seq%0d_pos_sum", i), 32'(sum), 32'(seq[i].expSum));
            checkOutput($sformatf("seq%0d_pos_cout", i), 32'(cout), 32'(seq[i].expCout));
            checkOutput($sformatf("seq%0d_sum_q", i), 32'(sum_q), 32'(seq[i].expSum));
            checkOutput($sformatf("seq%0d_cout_q", i), 32'(cout_q), 32'(seq[i].expCout));
            checkOutput($sformatf("seq%0d_cnt", i), 32'(cout_cnt), 32'(expCnt));
        end

        // Registered path: 110 captured on one edge, then inputs change mid-cycle.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reg110_cout_q", 32'(cout_q), 32'(1));
        checkOutput("reg110_sum_q", 32'(sum_q), 32'(0));
        checkOutput("reg110_cnt", 32'(cout_cnt), 32'(3));
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("midcyc_cout_q", 32'(cout_q), 32'(1));
        checkOutput("midcyc_sum_q", 32'(sum_q), 32'(0));
        checkOutput("midcyc_cnt", 32'(cout_cnt), 32'(3));
        @(posedge clk);
        #1;
        checkOutput("next_cout_q", 32'(cout_q), 32'(0));
        checkOutput("next_cnt", 32'(cout_cnt), 32'(3));

        // Async reset mid-cycle with 111 applied.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_sum_q", 32'(sum_q), 32'(1));
        checkOutput("pre_rst_cnt", 32'(cout_cnt), 32'(4));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_sum_q", 32'(sum_q), 32'(0));
        checkOutput("arst_cout_q", 32'(cout_q), 32'(0));
        checkOutput("arst_cnt", 32'(cout_cnt), 32'(0));
        checkOutput("arst_sum", 32'(sum), 32'(1));
        checkOutput("arst_cout", 32'(cout), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_cap_sum_q", 32'(sum_q), 32'(1));
        checkOutput("first_cap_cout_q", 32'(cout_q), 32'(1));
        checkOutput("first_cap_cnt", 32'(cout_cnt), 32'(1));
        expCnt   = 1;
        curCarry = 1'b1;

        // Random vectors on both edges; carries present at each rising edge feed the expected count.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (curCarry) expCnt++;
            #1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total = {1'b0, a} + {1'b0, b} + {1'b0, cin};
            #1;
            checkOutput("rand_pos_val", 32'({cout, sum}), 32'(total));
            checkOutput("rand_pos_x", 32'($isunknown({cout, sum})), 32'(0));
            @(negedge clk);
            #1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total = {1'b0, a} + {1'b0, b} + {1'b0, cin};
            curCarry = total[1];
            #1;
            checkOutput("rand_neg_val", 32'({cout, sum}), 32'(total));
            checkOutput("rand_neg_x", 32'($isunknown({cout, sum})), 32'(0));
        end
        @(posedge clk);
        if (curCarry) expCnt++;
        #1;
        checkOutput("rand_cnt", 32'(cout_cnt), 32'(expCnt));

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1);
        rstSat_n = 1'b0;
        #1;
        checkOutput("sat_rst_cnt", 32'(satCnt), 32'(0));
        checkOutput("sat_comb", 32'({satCout, satSum}), 32'(2));
        rstSat_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat_cnt%0d", i), 32'(satCnt), 32'(satExp[i]));
        end
        checkOutput("sat_regs", 32'({satCoutQ, satSumQ}), 32'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
